// File: rtl/grid_cell_mem_if.sv
// grid_cell_mem_if: cell write port between the editing logic (master) and
// the cell store (slave). busy reports a clear-all sweep in progress.
interface grid_cell_mem_if;
    logic       wr_req;
    logic [1:0] wr_op;
    logic [4:0] wr_col;
    logic [3:0] wr_row;
    logic       wr_ack;
    logic       busy;

    modport master (
        output wr_req, wr_op, wr_col, wr_row,
        input  wr_ack, busy
    );

    modport slave (
        input  wr_req, wr_op, wr_col, wr_row,
        output wr_ack, busy
    );
endinterface

// File: rtl/grid_cell_mem.sv
// grid_cell_mem: one-bit-per-cell store for a COLS x ROWS grid of 2**CELL_LOG2
// pixel cells, with a two-tick read pipeline feeding the pixel generator and a
// req/ack write port (clear, set, toggle, clear-all sweep).
// Optional: define GRID_POPCOUNT_EN to add the set_count output (cells set).
module grid_cell_mem #(
    parameter int unsigned COLS      = 20,
    parameter int unsigned ROWS      = 15,
    parameter int unsigned CELL_LOG2 = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           pclk_en,
    input  logic           valid_in,
    input  logic [9:0]     h_cnt_in,
    input  logic [9:0]     v_cnt_in,
    output logic           valid_out,
    output logic [9:0]     h_cnt_out,
    output logic [9:0]     v_cnt_out,
    output logic           mem_pixel,
`ifdef GRID_POPCOUNT_EN
    output logic [8:0]     set_count,
`endif
    grid_cell_mem_if.slave wr
);

    localparam int unsigned IdxW = 10 - CELL_LOG2;
    localparam int unsigned RowW = (ROWS > 1) ? $clog2(ROWS) : 1;

    localparam logic [1:0] OpClear    = 2'b00;
    localparam logic [1:0] OpSet      = 2'b01;
    localparam logic [1:0] OpToggle   = 2'b10;
    localparam logic [1:0] OpClearAll = 2'b11;

    typedef enum logic [0:0] {StIdle, StClear} state_e;

    state_e          state_q;
    logic [RowW-1:0] clr_row_q;
    logic            busy_q;

    logic [COLS-1:0] cells_q [ROWS];
    logic [COLS-1:0] cells_d [ROWS];

    logic            wr_accept;
    logic            cell_op;

    // Requests are only taken in IDLE; during a sweep they stay pending.
    assign wr_accept = wr.wr_req && (state_q == StIdle);
    assign cell_op   = wr_accept && (wr.wr_op != OpClearAll);
    assign wr.wr_ack = wr_accept;
    assign wr.busy   = busy_q;

    // Next cell contents: single-cell edits in IDLE, one row zeroed per clk in CLEAR.
    // Out-of-range targets match no cell and so change nothing.
    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            cells_d[r] = cells_q[r];
            if (state_q == StClear && clr_row_q == RowW'(r)) begin
                cells_d[r] = '0;
            end
            for (int c = 0; c < COLS; c++) begin
                if (cell_op && wr.wr_row == 4'(r) && wr.wr_col == 5'(c)) begin
                    case (wr.wr_op)
                        OpClear:  cells_d[r][c] = 1'b0;
                        OpSet:    cells_d[r][c] = 1'b1;
                        OpToggle: cells_d[r][c] = ~cells_q[r][c];
                        default:  cells_d[r][c] = cells_q[r][c];
                    endcase
                end
            end
        end
    end

    // Cell storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < ROWS; r++) begin
                cells_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < ROWS; r++) begin
                cells_q[r] <= cells_d[r];
            end
        end
    end

    // Write control FSM: accept edits in IDLE, sweep rows 0..ROWS-1 in CLEAR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            clr_row_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (wr_accept && wr.wr_op == OpClearAll) begin
                        state_q   <= StClear;
                        clr_row_q <= '0;
                        busy_q    <= 1'b1;
                    end
                end
                StClear: begin
                    if (clr_row_q == RowW'(ROWS - 1)) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end else begin
                        clr_row_q <= clr_row_q + RowW'(1);
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Read pipeline
    // ---------------------------------------------------------------------
    logic [IdxW-1:0] rd_row;
    logic [IdxW-1:0] rd_col;
    logic [COLS-1:0] rd_word;

    logic [COLS-1:0] s1_word_q;
    logic [IdxW-1:0] s1_col_q;
    logic            s1_valid_q;
    logic [9:0]      s1_h_q;
    logic [9:0]      s1_v_q;
    logic            s1_bit;

    logic            s2_valid_q;
    logic [9:0]      s2_h_q;
    logic [9:0]      s2_v_q;
    logic            s2_pix_q;

    assign rd_row = v_cnt_in[9:CELL_LOG2];
    assign rd_col = h_cnt_in[9:CELL_LOG2];

    // Stage-1 row select; rows below the grid read as an all-zero word.
    always_comb begin
        rd_word = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (rd_row == IdxW'(r)) begin
                rd_word = cells_q[r];
            end
        end
    end

    // Stage-2 bit select; columns right of the grid read as zero.
    always_comb begin
        s1_bit = 1'b0;
        for (int c = 0; c < COLS; c++) begin
            if (s1_col_q == IdxW'(c)) begin
                s1_bit = s1_word_q[c];
            end
        end
    end

    // Two pipeline stages advancing on pixel ticks; stage 1 samples the
    // pre-write row, so a same-edge write shows up one tick later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_word_q  <= '0;
            s1_col_q   <= '0;
            s1_valid_q <= 1'b0;
            s1_h_q     <= '0;
            s1_v_q     <= '0;
            s2_valid_q <= 1'b0;
            s2_h_q     <= '0;
            s2_v_q     <= '0;
            s2_pix_q   <= 1'b0;
        end else if (pclk_en) begin
            s1_word_q  <= rd_word;
            s1_col_q   <= rd_col;
            s1_valid_q <= valid_in;
            s1_h_q     <= h_cnt_in;
            s1_v_q     <= v_cnt_in;
            s2_valid_q <= s1_valid_q;
            s2_h_q     <= s1_h_q;
            s2_v_q     <= s1_v_q;
            s2_pix_q   <= s1_bit;
        end
    end

    assign valid_out = s2_valid_q;
    assign h_cnt_out = s2_h_q;
    assign v_cnt_out = s2_v_q;
    assign mem_pixel = s2_pix_q;

`ifdef GRID_POPCOUNT_EN
    logic [8:0] count_q;
    logic       cur_bit;
    logic       cell_hit;

    // Old value of the addressed cell; cell_hit stays low for out-of-range targets.
    always_comb begin
        cur_bit  = 1'b0;
        cell_hit = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (wr.wr_row == 4'(r) && wr.wr_col == 5'(c)) begin
                    cell_hit = 1'b1;
                    cur_bit  = cells_q[r][c];
                end
            end
        end
    end

    // Count only edits that actually flip a cell; clear-all zeroes it on entry to CLEAR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (wr_accept) begin
            if (wr.wr_op == OpClearAll) begin
                count_q <= '0;
            end else if (cell_hit) begin
                case (wr.wr_op)
                    OpSet:    if (!cur_bit) count_q <= count_q + 9'd1;
                    OpClear:  if (cur_bit) count_q <= count_q - 9'd1;
                    OpToggle: count_q <= cur_bit ? (count_q - 9'd1) : (count_q + 9'd1);
                    default:  count_q <= count_q;
                endcase
            end
        end
    end

    assign set_count = count_q;
`endif

endmodule

// File: tb/tb_grid_cell_mem.sv
// tb_grid_cell_mem: randomized + directed stimulus against a cell-array model;
// expected pixels and per-cycle handshake values are queued by the driver and
// compared by independent monitor processes.
module tb_grid_cell_mem;
    localparam int COLS = 20;
    localparam int ROWS = 15;

    typedef struct {
        logic       valid;
        logic [9:0] h;
        logic [9:0] v;
        logic       pix;
    } pix_t;

    typedef struct {
        logic       ack;
        logic       busy;
        logic [8:0] cnt;
    } cyc_t;

    typedef struct {
        logic [1:0] op;
        logic [4:0] col;
        logic [3:0] row;
    } wr_t;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       pclk_en  = 1'b0;
    logic       valid_in = 1'b0;
    logic [9:0] h_cnt_in = '0;
    logic [9:0] v_cnt_in = '0;
    logic       valid_out;
    logic [9:0] h_cnt_out;
    logic [9:0] v_cnt_out;
    logic       mem_pixel;
`ifdef GRID_POPCOUNT_EN
    logic [8:0] set_count;
`endif

    grid_cell_mem_if bus ();

    grid_cell_mem #(
        .COLS      (COLS),
        .ROWS      (ROWS),
        .CELL_LOG2 (5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pclk_en   (pclk_en),
        .valid_in  (valid_in),
        .h_cnt_in  (h_cnt_in),
        .v_cnt_in  (v_cnt_in),
        .valid_out (valid_out),
        .h_cnt_out (h_cnt_out),
        .v_cnt_out (v_cnt_out),
        .mem_pixel (mem_pixel),
`ifdef GRID_POPCOUNT_EN
        .set_count (set_count),
`endif
        .wr        (bus.slave)
    );

    initial forever #5 clk = ~clk;

    // Reference model state
    bit   model [ROWS][COLS];
    int   clr_left;
    pix_t pix_q [$];
    cyc_t cyc_q [$];
    wr_t  wq [$];

    int n_cmp = 0;
    int n_bad = 0;
    int ticks = 0;
    int phase = 0;
    int pix_mode = 0;
    int h_pos, v_pos, scan_off;
    bit scan_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic logic model_bit(input int h, input int v);
        int r = v / 32;
        int c = h / 32;
        if (r < ROWS && c < COLS) return model[r][c];
        return 1'b0;
    endfunction

    function automatic int model_count();
        int n = 0;
        if (clr_left != 0) return 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                n += int'(model[r][c]);
        return n;
    endfunction

    task automatic model_apply(input wr_t w);
        int r = int'(w.row);
        int c = int'(w.col);
        if (w.op == 2'b11) begin
            clr_left = ROWS;
        end else if (r < ROWS && c < COLS) begin
            case (w.op)
                2'b00:   model[r][c] = 1'b0;
                2'b01:   model[r][c] = 1'b1;
                default: model[r][c] = ~model[r][c];
            endcase
        end
    endtask

    task automatic push_wr(input int op, input int col, input int row);
        wr_t w;
        w.op  = 2'(op);
        w.col = 5'(col);
        w.row = 4'(row);
        wq.push_back(w);
    endtask

    task automatic next_pixel();
        int h, v;
        if (pix_mode == 0) begin
            h = h_pos;
            v = v_pos;
            h_pos += 16;
            if (h_pos >= 800) begin
                h_pos = scan_off;
                v_pos += 16;
                if (v_pos >= 525) begin
                    v_pos     = scan_off;
                    scan_done = 1'b1;
                end
            end
        end else if ($urandom_range(0, 7) == 0) begin
            h = int'($urandom_range(0, 799));
            v = int'($urandom_range(0, 524));
        end else begin
            h = int'($urandom_range(0, 127));
            v = int'($urandom_range(0, 127));
        end
        h_cnt_in = 10'(h);
        v_cnt_in = 10'(v);
        valid_in = (h < 640) && (v < 480);
    endtask

    // One clk: drive inputs, queue expectations, then advance the model past the edge.
    task automatic step();
        pix_t p;
        cyc_t e;
        logic ack_exp;
        @(negedge clk);
        pclk_en = (phase == 3);
        phase   = (phase + 1) % 4;
        if (pclk_en) begin
            next_pixel();
            p.valid = valid_in;
            p.h     = h_cnt_in;
            p.v     = v_cnt_in;
            p.pix   = model_bit(int'(h_cnt_in), int'(v_cnt_in));
            pix_q.push_back(p);
        end
        if (wq.size() > 0) begin
            bus.wr_req = 1'b1;
            bus.wr_op  = wq[0].op;
            bus.wr_col = wq[0].col;
            bus.wr_row = wq[0].row;
        end else begin
            bus.wr_req = 1'b0;
            bus.wr_op  = 2'($urandom);
            bus.wr_col = 5'($urandom);
            bus.wr_row = 4'($urandom);
        end
        ack_exp = bus.wr_req && (clr_left == 0);
        e.ack   = ack_exp;
        e.busy  = (clr_left != 0);
        e.cnt   = 9'(model_count());
        cyc_q.push_back(e);
        if (clr_left != 0) begin
            for (int c = 0; c < COLS; c++) model[ROWS - clr_left][c] = 1'b0;
            clr_left--;
        end else if (ack_exp) begin
            model_apply(wq[0]);
            void'(wq.pop_front());
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.wr_req = 1'b0;
        pclk_en    = 1'b0;
        rst_n      = 1'b0;
        #1;
        check("rst_busy", bus.busy, 1'b0);
        check("rst_ack", bus.wr_ack, 1'b0);
        check("rst_valid_out", valid_out, 1'b0);
        check("rst_h_cnt_out", h_cnt_out, 10'd0);
        check("rst_v_cnt_out", v_cnt_out, 10'd0);
        check("rst_mem_pixel", mem_pixel, 1'b0);
`ifdef GRID_POPCOUNT_EN
        check("rst_set_count", set_count, 9'd0);
`endif
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                model[r][c] = 1'b0;
        clr_left = 0;
        pix_q.delete();
        cyc_q.delete();
        wq.delete();
        ticks = 0;
        phase = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_scan(input int off);
        int guard = 0;
        pix_mode  = 0;
        scan_off  = off;
        h_pos     = off;
        v_pos     = off;
        scan_done = 1'b0;
        while (!scan_done && guard < 20000) begin
            step();
            guard++;
        end
    endtask

    task automatic drain();
        int guard = 0;
        while ((wq.size() > 0 || clr_left != 0) && guard < 400) begin
            step();
            guard++;
        end
        if (guard >= 400) begin
            n_bad++;
            $display("FAIL drain: write queue still has %0d entries", wq.size());
        end
        repeat (12) step();
    endtask

    // Pixel monitor: after the k-th pixel tick the outputs carry pixel k-1.
    initial begin
        pix_t e;
        forever begin
            @(posedge clk);
            if (rst_n && pclk_en) begin
                ticks++;
                #1;
                if (ticks >= 2 && pix_q.size() > 0) begin
                    e = pix_q.pop_front();
                    check("valid_out", valid_out, e.valid);
                    check("h_cnt_out", h_cnt_out, e.h);
                    check("v_cnt_out", v_cnt_out, e.v);
                    check("mem_pixel", mem_pixel, e.pix);
                end else if (ticks == 1) begin
                    check("fill_valid_out", valid_out, 1'b0);
                    check("fill_mem_pixel", mem_pixel, 1'b0);
                end
            end
        end
    end

    // Handshake monitor: per-clk ack/busy/count, sampled mid-cycle.
    initial begin
        cyc_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && cyc_q.size() > 0) begin
                e = cyc_q.pop_front();
                check("wr_ack", bus.wr_ack, e.ack);
                check("busy", bus.busy, e.busy);
`ifdef GRID_POPCOUNT_EN
                check("set_count", set_count, e.cnt);
`endif
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        bus.wr_req = 1'b0;
        bus.wr_op  = '0;
        bus.wr_col = '0;
        bus.wr_row = '0;
        clr_left   = 0;
        do_reset();

        // Empty grid across the whole raster, including blanking coordinates.
        run_scan(0);

        // Single cell (3,2): hits 96..127 x 64..95.
        push_wr(1, 3, 2);
        drain();
        run_scan(0);
        run_scan(15);

        // Toggle twice and an out-of-range set.
        pix_mode = 1;
        push_wr(2, 0, 0);
        drain();
        push_wr(2, 0, 0);
        drain();
        push_wr(1, 25, 2);
        drain();

        // Five sets, clear-all, and a set queued behind the sweep.
        push_wr(1, 0, 0);
        push_wr(1, 2, 1);
        push_wr(1, 19, 14);
        push_wr(1, 3, 3);
        push_wr(1, 1, 0);
        push_wr(3, 0, 0);
        push_wr(1, 1, 1);
        drain();
        run_scan(0);

        // Random edits overlapping random reads of the same rows.
        pix_mode = 1;
        for (int i = 0; i < 4000; i++) begin
            if (wq.size() == 0 && $urandom_range(0, 3) == 0) begin
                push_wr(($urandom_range(0, 39) == 0) ? 3 : int'($urandom_range(0, 2)),
                        ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 31))
                                                    : int'($urandom_range(0, 3)),
                        ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15))
                                                    : int'($urandom_range(0, 3)));
            end
            step();
        end
        drain();

        // Reset while the sweep is on row 7.
        push_wr(1, 4, 10);
        push_wr(1, 5, 12);
        push_wr(1, 6, 3);
        push_wr(3, 0, 0);
        guard = 0;
        while (clr_left != 8 && guard < 100) begin
            step();
            guard++;
        end
        if (guard >= 100) begin
            n_bad++;
            $display("FAIL sweep_row7: sweep position not reached, clr_left %0d", clr_left);
        end
        do_reset();
        run_scan(0);
        push_wr(1, 2, 2);
        drain();
        pix_mode = 1;
        repeat (40) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
